// File: rtl/seller_uart_tx_if.sv
// Handshake bundle between the seller FSM and the reply-frame UART transmitter.
interface seller_uart_tx_if;
  logic       en;
  logic [7:0] uart_out;
  logic [15:0] amount;
  logic       tx;
  logic       busy;
  logic       done;

  modport master (
    output en, uart_out, amount,
    input  tx, busy, done
  );

  modport slave (
    input  en, uart_out, amount,
    output tx, busy, done
  );
endinterface

// File: rtl/seller_uart_tx.sv
// Reply-frame UART transmitter: on a rising edge of en, sends
// HEADER, code, amount[15:8], amount[7:0], XOR checksum as 8N1, LSB first.
module seller_uart_tx #(
  parameter int         SYSCLK = 125_000_000,
  parameter int         BAUD   = 115200,
  parameter logic [7:0] HEADER = 8'hAA
) (
  input logic            clk,
  input logic            rst_n,
  seller_uart_tx_if.slave bus
);

  localparam int BAUD_DIV = SYSCLK / BAUD;
  localparam int CNT_W    = (BAUD_DIV < 2) ? 1 : $clog2(BAUD_DIV);

  if (BAUD_DIV < 2) begin : g_baud_check
    $error("seller_uart_tx: BAUD_DIV must be at least 2");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  logic             en_d;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [2:0]       byte_idx;
  logic             tx_q;
  logic             busy_q;
  logic             done_q;

  logic [7:0]       code;
  logic [7:0]       amt_hi;
  logic [7:0]       amt_lo;
  logic [7:0]       chk;
  logic [7:0]       cur_byte;

  logic             trig;
  logic             cnt_last;
  logic [2:0]       next_bit;

  assign trig     = bus.en & ~en_d;
  assign cnt_last = (cnt == CNT_W'(BAUD_DIV - 1));
  assign next_bit = bit_idx + 3'd1;

  always_comb begin
    cur_byte = chk;
    case (byte_idx)
      3'd0:    cur_byte = HEADER;
      3'd1:    cur_byte = code;
      3'd2:    cur_byte = amt_hi;
      3'd3:    cur_byte = amt_lo;
      default: cur_byte = chk;
    endcase
  end

  // Frame payload is latched only when a trigger is accepted, so it stays frozen mid-frame.
  always_ff @(posedge clk) begin
    if (state == IDLE && trig) begin
      code   <= bus.uart_out;
      amt_hi <= bus.amount[15:8];
      amt_lo <= bus.amount[7:0];
      chk    <= HEADER ^ bus.uart_out ^ bus.amount[15:8] ^ bus.amount[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      en_d     <= 1'b0;
      cnt      <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      en_d   <= bus.en;
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (trig) begin
            state    <= START;
            cnt      <= '0;
            byte_idx <= '0;
            tx_q     <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        START: begin
          if (cnt_last) begin
            state   <= DATA;
            cnt     <= '0;
            bit_idx <= '0;
            tx_q    <= cur_byte[0];
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt_last) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx_q  <= 1'b1;
            end else begin
              bit_idx <= next_bit;
              tx_q    <= cur_byte[next_bit];
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (cnt_last) begin
            cnt <= '0;
            // Next byte's start bit follows the stop bit directly, no idle gap.
            if (byte_idx < 3'd4) begin
              byte_idx <= byte_idx + 3'd1;
              state    <= START;
              tx_q     <= 1'b0;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state  <= IDLE;
          cnt    <= '0;
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tx   = tx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_seller_uart_tx.sv
// Directed bench for seller_uart_tx with BAUD_DIV = 8 (SYSCLK=8, BAUD=1).
module tb_seller_uart_tx;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  seller_uart_tx_if bus();

  seller_uart_tx #(.SYSCLK(8), .BAUD(1), .HEADER(8'hAA)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Waits for the start bit, then decodes five bytes sampling every cycle,
  // checks bit stability, framing, busy width and the done pulse position.
  task automatic recv_frame(input logic [39:0] exp, input string name);
    bit         found;
    logic [7:0] got;
    logic       first;
    logic       stable;
    logic       frame_ok;
    int         busy_cnt;
    int         done_cnt;
    int         b, j, k;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (bus.tx === 1'b0) found = 1;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL %s start: tx stayed %b, expected a start bit", name, bus.tx);
      return;
    end
    busy_cnt = 0; done_cnt = 0;
    got = '0; first = 1'b0; stable = 1'b1; frame_ok = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (c > 0) @(negedge clk);
      b = c / 80; j = (c % 80) / 8; k = c % 8;
      if (k == 0) first = bus.tx;
      else if (bus.tx !== first) stable = 1'b0;
      if (k == 3) begin
        if (j == 0)      frame_ok = frame_ok & (bus.tx === 1'b0);
        else if (j == 9) frame_ok = frame_ok & (bus.tx === 1'b1);
        else             got[j-1] = bus.tx;
      end
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.done === 1'b1) done_cnt++;
      if (c % 80 == 79) begin
        n_cmp++;
        if (got !== exp[39-8*b -: 8]) begin
          n_bad++;
          $display("FAIL %s byte%0d: got %h expected %h", name, b, got, exp[39-8*b -: 8]);
        end
        n_cmp++;
        if ({frame_ok, stable} !== 2'b11) begin
          n_bad++;
          $display("FAIL %s framing byte%0d: framing_ok=%b stable=%b expected 1 1", name, b, frame_ok, stable);
        end
        frame_ok = 1'b1; stable = 1'b1;
      end
    end
    n_cmp++;
    if (busy_cnt !== 400 || done_cnt !== 0) begin
      n_bad++;
      $display("FAIL %s busy_window: busy cycles %0d done pulses %0d, expected 400 and 0", name, busy_cnt, done_cnt);
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.busy, bus.done, bus.tx} !== 3'b011) begin
      n_bad++;
      $display("FAIL %s end: busy,done,tx=%b expected 011", name, {bus.busy, bus.done, bus.tx});
    end
    @(negedge clk);
    n_cmp++;
    if (bus.done !== 1'b0) begin
      n_bad++;
      $display("FAIL %s done_width: done=%b expected 0", name, bus.done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.en = 1'b0; bus.uart_out = 8'h00; bus.amount = 16'h0000;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.tx, bus.busy, bus.done} !== 3'b100) begin
      n_bad++;
      $display("FAIL reset: tx,busy,done=%b expected 100", {bus.tx, bus.busy, bus.done});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.tx, bus.busy, bus.done} !== 3'b100) begin
      n_bad++;
      $display("FAIL idle_after_reset: tx,busy,done=%b expected 100", {bus.tx, bus.busy, bus.done});
    end
  endtask

  task automatic test_basic_frame();
    bus.uart_out = 8'h15; bus.amount = 16'h0024;
    bus.en = 1'b1;
    recv_frame({8'hAA, 8'h15, 8'h00, 8'h24, 8'h9B}, "basic");
    bus.en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_hold_en();
    int extra_low;
    int extra_done;
    bus.uart_out = 8'h42; bus.amount = 16'h0100;
    bus.en = 1'b1;
    recv_frame({8'hAA, 8'h42, 8'h01, 8'h00, 8'hE9}, "hold_en");
    extra_low = 0; extra_done = 0;
    repeat (598) begin
      @(negedge clk);
      if (bus.tx !== 1'b1) extra_low++;
      if (bus.done !== 1'b0) extra_done++;
    end
    n_cmp++;
    if (extra_low !== 0 || extra_done !== 0) begin
      n_bad++;
      $display("FAIL hold_en_retrigger: tx low %0d cycles, done %0d, expected 0 and 0", extra_low, extra_done);
    end
    bus.en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ignored_trigger();
    int extra_low;
    bus.uart_out = 8'h15; bus.amount = 16'h0024;
    bus.en = 1'b1;
    fork
      recv_frame({8'hAA, 8'h15, 8'h00, 8'h24, 8'h9B}, "busy_trigger");
      begin
        repeat (100) @(negedge clk);
        bus.en = 1'b0; bus.uart_out = 8'h33;
        @(negedge clk);
        bus.en = 1'b1;
        @(negedge clk);
        bus.en = 1'b0;
      end
    join
    extra_low = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0) extra_low++;
    end
    n_cmp++;
    if (extra_low !== 0) begin
      n_bad++;
      $display("FAIL busy_trigger_queued: %0d active cycles after frame, expected 0", extra_low);
    end
  endtask

  task automatic test_frozen_inputs();
    bus.uart_out = 8'h5A; bus.amount = 16'hC3E1;
    bus.en = 1'b1;
    fork
      recv_frame({8'hAA, 8'h5A, 8'hC3, 8'hE1, 8'hD2}, "frozen");
      begin
        repeat (405) begin
          @(negedge clk);
          bus.uart_out = 8'($urandom);
          bus.amount   = 16'($urandom);
        end
      end
    join
    bus.en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    int seen_done;
    bus.uart_out = 8'h77; bus.amount = 16'h8888;
    bus.en = 1'b1;
    repeat (151) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.tx, bus.busy, bus.done} !== 3'b100) begin
      n_bad++;
      $display("FAIL mid_reset: tx,busy,done=%b expected 100", {bus.tx, bus.busy, bus.done});
    end
    seen_done = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done !== 1'b0) seen_done++;
    end
    // en is high at release, so the first edge afterwards triggers a fresh frame.
    bus.uart_out = 8'h01; bus.amount = 16'h1234;
    rst_n = 1'b1;
    recv_frame({8'hAA, 8'h01, 8'h12, 8'h34, 8'h8D}, "after_reset");
    n_cmp++;
    if (seen_done !== 0) begin
      n_bad++;
      $display("FAIL mid_reset_done: done seen %0d times, expected 0", seen_done);
    end
    bus.en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_all_ones();
    bus.uart_out = 8'hFF; bus.amount = 16'hFFFF;
    bus.en = 1'b1;
    recv_frame({8'hAA, 8'hFF, 8'hFF, 8'hFF, 8'h55}, "all_ones");
    bus.en = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_basic_frame();
    test_hold_en();
    test_ignored_trigger();
    test_frozen_inputs();
    test_mid_reset();
    test_all_ones();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
